// File: rtl/denise_palette_mp.sv
// denise_palette_mp: multi-port Denise colour palette, readback path and clear sequencer.
// Optional feature macro: DENISE_PALETTE_EHB_EN (extra-half-brite lookup).
module denise_palette_mp #(
    parameter int SEL_W = 8,
    parameter int PORTS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk7_en,
    input  logic [8:1]               reg_address_in,
    input  logic [11:0]              data_in,
    input  logic [2:0]               bank,
    input  logic                     loct,
    input  logic                     ehb_en,
    input  logic [SEL_W-1:0]         bplxor,
    input  logic [PORTS-1:0]         xor_en,
    input  logic [PORTS*SEL_W-1:0]   sel,
    output logic [PORTS*24-1:0]      rgb,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [11:0]              rd_data,
    output logic                     init_busy
);

    localparam int N = 1 << SEL_W;

    typedef enum logic {CLEAR, RUN} clr_t;
    typedef enum logic [1:0] {IDLE, FETCH, ACK} rd_t;

    logic [23:0]      mem [N];

    clr_t             clr_st;
    logic [SEL_W-1:0] clr_cnt;

    rd_t              rd_st;
    logic [SEL_W-1:0] rd_addr;
    logic             rd_loct;
    logic [23:0]      rd_word;
    logic [23:0]      fetch_word;
    logic [11:0]      rd_hi;
    logic [11:0]      rd_lo;

    logic [7:0]       wr_full;
    logic [SEL_W-1:0] wr_idx;
    logic             wr_hit;
    logic             wr_en;
    logic [23:0]      wr_old;
    logic [23:0]      wr_val;

    assign init_busy = (clr_st == CLEAR);

    // Index MSBs come from the bank; unused upper bank bits fall off the top.
    assign wr_full = {bank, reg_address_in[5:1]};
    assign wr_idx  = wr_full[SEL_W-1:0];
    assign wr_hit  = (reg_address_in[8:6] == 3'b110);
    assign wr_en   = clk7_en && wr_hit && !init_busy;
    assign wr_old  = mem[wr_idx];

    assign wr_val = loct
        ? {wr_old[23:20], data_in[11:8],
           wr_old[15:12], data_in[7:4],
           wr_old[7:4],   data_in[3:0]}
        : {data_in[11:8], data_in[11:8],
           data_in[7:4],  data_in[7:4],
           data_in[3:0],  data_in[3:0]};

    always_ff @(posedge clk) begin
        if (clr_st == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_st  <= CLEAR;
            clr_cnt <= '0;
        end else if (clr_st == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) begin
                clr_st <= RUN;
            end
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] addr;
        logic             half;
        logic             half1;
        logic             half2;
        logic [23:0]      dat1;
        logic [23:0]      dat2;
        logic [23:0]      out_q;

        assign idx = sel[p*SEL_W +: SEL_W] ^ (xor_en[p] ? bplxor : '0);

`ifdef DENISE_PALETTE_EHB_EN
        assign addr = ehb_en ? {{(SEL_W-5){1'b0}}, idx[4:0]} : idx;
        assign half = ehb_en & idx[5];
`else
        assign addr = idx;
        assign half = 1'b0;
`endif

        // Array is read on the sampling edge, so a same-edge write is not seen.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dat1  <= '0;
                half1 <= 1'b0;
                dat2  <= '0;
                half2 <= 1'b0;
                out_q <= '0;
            end else begin
                dat1  <= init_busy ? 24'h0 : mem[addr];
                half1 <= half & !init_busy;
                dat2  <= dat1;
                half2 <= half1;
                out_q <= half2
                    ? {1'b0, dat2[23:17], 1'b0, dat2[15:9], 1'b0, dat2[7:1]}
                    : dat2;
            end
        end

        assign rgb[p*24 +: 24] = out_q;
    end

`ifndef DENISE_PALETTE_EHB_EN
    logic unused_ehb;
    assign unused_ehb = ehb_en;
`endif

    // Forward a bus write landing on the entry being fetched.
    assign fetch_word = (wr_en && (wr_idx == rd_addr)) ? wr_val : mem[rd_addr];

    assign rd_hi = {rd_word[23:20], rd_word[15:12], rd_word[7:4]};
    assign rd_lo = {rd_word[19:16], rd_word[11:8], rd_word[3:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_st   <= IDLE;
            rd_addr <= '0;
            rd_loct <= 1'b0;
            rd_word <= '0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack <= 1'b0;
            unique case (rd_st)
                IDLE: begin
                    if (rd_req && !init_busy) begin
                        rd_addr <= wr_idx;
                        rd_loct <= loct;
                        rd_st   <= FETCH;
                    end
                end
                FETCH: begin
                    rd_word <= fetch_word;
                    rd_st   <= ACK;
                end
                ACK: begin
                    rd_ack  <= 1'b1;
                    rd_data <= rd_loct ? rd_lo : rd_hi;
                    rd_st   <= IDLE;
                end
                default: begin
                    rd_st <= IDLE;
                end
            endcase
        end
    end

endmodule
